// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the CPU front-end blocks.
//   INSTR_W      instruction word width
//   PC_STEP      byte distance between sequential instruction addresses
//   ADDR_W_DEF   default PC / instruction-memory address width
//   RESET_PC_DEF default first fetch address after reset
//   cnt_w()      width of a counter that must hold 0..depth inclusive
package cpu_pkg;

  localparam int          INSTR_W      = 32;
  localparam int          PC_STEP      = 4;
  localparam int          ADDR_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO holding fetched {instruction, pc} entries.
//   clk, rst_n    clock, synchronous active-low reset (control state only)
//   clear         drops all entries; wins over push, a same-cycle pop is ignored
//   push, din     write an entry (ignored when full)
//   pop           retire the head entry (ignored when empty)
//   dout          head entry, valid while !empty
//   count         number of stored entries (0..DEPTH)
//   empty, full   occupancy flags
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        push,
  input  logic [WIDTH-1:0]            din,
  input  logic                        pop,
  output logic [WIDTH-1:0]            dout,
  output logic [cnt_w(DEPTH)-1:0]     count,
  output logic                        empty,
  output logic                        full
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; entries are only read once counted in.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
//   clk, rst_n                      clock, synchronous active-low reset
//   imem_req_valid/ready/addr       in-order fetch requests to instruction memory
//   imem_rsp_valid/data             returned words, in request order
//   redirect_valid, redirect_pc     taken-branch pulse and target (bits [1:0] ignored)
//   instr_valid/ready, instr,       head of the instruction buffer to decode
//   instr_pc
// Requests are credit limited: outstanding + buffered never exceeds DEPTH, so
// the buffer cannot overflow. A redirect flushes the buffer and marks every
// request still in flight (including one accepted in the same cycle) as stale.
// Optional macro FETCH_TRACE_EN: prints each delivered instruction and each
// redirect during simulation; behaviour is otherwise identical.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc
);

  localparam int                CW      = cnt_w(DEPTH);
  localparam int                EW      = INSTR_W + ADDR_W;
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
  localparam logic [CW:0]       DEPTH_C = (CW + 1)'(DEPTH);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [ADDR_W-1:0] redirect_tgt;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     discard;
  logic [CW-1:0]     out_next;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credit_used;
  logic              fifo_empty;
  logic              fifo_full;
  logic              req_fire;
  logic              push;
  logic              pop;
  logic [EW-1:0]     head;

  assign redirect_tgt   = redirect_pc & ~ADDR_W'(3);
  assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = rst_n && (credit_used < DEPTH_C);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign out_next       = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

  // A response arriving with a redirect belongs to the old stream.
  assign push        = imem_rsp_valid && (discard == '0) && !redirect_valid;
  assign instr_valid = !fifo_empty;
  assign pop         = instr_valid && instr_ready;
  assign {instr, instr_pc} = head;

  // Request / response bookkeeping -> buffer write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      assert (!imem_rsp_valid || (outstanding != '0));
      assert (!push || !fifo_full);
      outstanding <= out_next;
      if (redirect_valid) begin
        pc      <= redirect_tgt;
        rsp_pc  <= redirect_tgt;
        discard <= out_next;
      end else begin
        if (req_fire) pc <= pc + STEP;
        if (push) begin
          rsp_pc <= rsp_pc + STEP;
        end else if (imem_rsp_valid) begin
          discard <= discard - CW'(1);
        end
      end
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (redirect_valid),
    .push  (push),
    .din   ({imem_rsp_data, rsp_pc}),
    .pop   (pop),
    .dout  (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

`ifdef FETCH_TRACE_EN
  // Snapshot at the edge so $strobe reports the retired entry, not the new head.
  logic [ADDR_W-1:0]  tr_pc;
  logic [INSTR_W-1:0] tr_instr;
  logic [ADDR_W-1:0]  tr_tgt;
  logic [CW-1:0]      tr_disc;

  always_ff @(posedge clk) begin
    tr_pc    <= instr_pc;
    tr_instr <= instr;
    tr_tgt   <= redirect_tgt;
    tr_disc  <= out_next;
    if (rst_n && pop)
      $strobe("(FETCH) pc = %h, instr = %h", tr_pc, tr_instr);
    if (rst_n && redirect_valid)
      $strobe("(FETCH) redirect pc = %h, discarded = %0d", tr_tgt, tr_disc);
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_instr_valid;
  logic [31:0] w_instr;
  logic [31:0] w_instr_pc;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  // Second instance only observes the reset-address wrap.
  fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(w_req_addr), .imem_rsp_valid(1'b0),
    .imem_rsp_data(32'h0), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .instr_valid(w_instr_valid),
    .instr_ready(1'b0), .instr(w_instr), .instr_pc(w_instr_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] exp_q[$];
  logic [31:0] wq[$];
  logic [31:0] model_pc;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int pops    = 0;

  bit ird = 1'b1, ird_rand = 1'b0;
  bit rdy_fix = 1'b1, rdy_rand = 1'b0;
  bit lat_rand = 1'b0;
  int lat = 1;
  bit redir_now = 1'b0, redir_busy = 1'b0, redir_fired = 1'b0;
  logic [31:0] redir_tgt = 32'h0;
  bit acc_seen, pop_seen;
  logic [31:0] acc_addr, pop_pc;

  // One clock cycle: drive inputs at the negedge, score handshakes, step to next negedge.
  task automatic tick();
    bit          do_redir;
    int          d;
    logic [31:0] e;
    acc_seen = 1'b0;
    pop_seen = 1'b0;
    imem_req_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : rdy_fix;
    instr_ready    = ird_rand ? ($urandom_range(0, 3) != 0) : ird;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~mq[0].addr;
      void'(mq.pop_front());
    end
    #1;
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
      model_pc = 32'h0;
    end else begin
      do_redir = redir_now ||
                 (redir_busy && imem_req_valid && imem_req_ready && imem_rsp_valid);
      redirect_valid = do_redir;
      redirect_pc    = redir_tgt;
      acc_seen = imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;
      pop_seen = instr_valid && instr_ready;
      if (w_req_valid) wq.push_back(w_req_addr);
      if (pop_seen) begin
        pop_pc = instr_pc;
        pops++;
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL stream_extra: got pc %h instr %h, expected no instruction", instr_pc, instr);
        end else begin
          e = exp_q.pop_front();
          if (instr_pc !== e || instr !== ~e)
            $display("FAIL stream: got pc %h instr %h, expected pc %h instr %h", instr_pc, instr, e, ~e);
          else
            n_pass++;
        end
      end
      if (acc_seen) begin
        n_total++;
        if (acc_addr !== model_pc)
          $display("FAIL req_addr: got %h, expected %h", acc_addr, model_pc);
        else
          n_pass++;
        d = cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat);
        mq.push_back('{addr: acc_addr, due: d});
      end
      if (do_redir) begin
        exp_q.delete();
        model_pc    = redir_tgt & ~32'h3;
        redir_fired = 1'b1;
        redir_busy  = 1'b0;
      end else if (acc_seen) begin
        exp_q.push_back(model_pc);
        model_pc = model_pc + 32'd4;
      end
    end
    redir_now = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int k;
    rst_n = 1'b0;
    repeat (3) tick();
    n_total++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || w_req_valid !== 1'b0)
      $display("FAIL reset_state: req_valid %b instr_valid %b w_req_valid %b, expected 0 0 0",
               imem_req_valid, instr_valid, w_req_valid);
    else n_pass++;
    rst_n = 1'b1;
    for (k = 0; k < 10; k++) begin
      if (instr_valid === 1'b1) break;
      tick();
    end
    n_total++;
    if (k !== 2) $display("FAIL first_valid: got %0d cycles, expected 2", k);
    else n_pass++;
    n_total++;
    if (instr_pc !== 32'h0) $display("FAIL first_pc: got %h, expected 00000000", instr_pc);
    else n_pass++;
  endtask

  task automatic test_stream();
    int start;
    start = pops;
    repeat (20) tick();
    n_total++;
    if (pops - start < 10) $display("FAIL stream_rate: got %0d pops in 20 cycles, expected >= 10", pops - start);
    else n_pass++;
  endtask

  task automatic test_wrap();
    n_total++;
    if (wq.size() !== 2) $display("FAIL wrap_count: got %0d requests, expected 2", wq.size());
    else n_pass++;
    if (wq.size() >= 2) begin
      n_total++;
      if (wq[0] !== 32'hFFFF_FFFC || wq[1] !== 32'h0000_0000)
        $display("FAIL wrap_addr: got %h %h, expected fffffffc 00000000", wq[0], wq[1]);
      else n_pass++;
    end
    n_total++;
    if (w_req_valid !== 1'b0 || w_instr_valid !== 1'b0)
      $display("FAIL wrap_idle: req_valid %b instr_valid %b, expected 0 0", w_req_valid, w_instr_valid);
    else n_pass++;
  endtask

  task automatic test_stall();
    int          accs;
    int          got;
    logic [31:0] pcs[2];
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    ird = 1'b0;
    lat = 1;
    accs = 0;
    repeat (10) begin
      tick();
      if (acc_seen) accs++;
    end
    n_total++;
    if (accs !== 2) $display("FAIL stall_reqs: got %0d, expected 2", accs);
    else n_pass++;
    n_total++;
    if (imem_req_valid !== 1'b0) $display("FAIL stall_req_low: got %b, expected 0", imem_req_valid);
    else n_pass++;
    ird = 1'b1;
    got = 0;
    pcs[0] = 32'hx;
    pcs[1] = 32'hx;
    for (int i = 0; i < 10 && got < 2; i++) begin
      tick();
      if (pop_seen) begin
        pcs[got] = pop_pc;
        got++;
      end
    end
    n_total++;
    if (pcs[0] !== 32'h0 || pcs[1] !== 32'h4)
      $display("FAIL stall_release: got %h %h, expected 00000000 00000004", pcs[0], pcs[1]);
    else n_pass++;
  endtask

  task automatic test_redirect();
    bit found;
    ird = 1'b1;
    lat = 3;
    repeat (6) tick();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mq.size() == 2) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_total++;
    if (!found) $display("FAIL redir_setup: in-flight %0d, expected 2", mq.size());
    else n_pass++;
    redir_tgt = 32'h100;
    redir_now = 1'b1;
    tick();
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (pop_seen) begin
        found = 1'b1;
        break;
      end
    end
    n_total++;
    if (!found || pop_pc !== 32'h100)
      $display("FAIL redir_target: got pc %h (seen %b), expected 00000100", pop_pc, found);
    else n_pass++;
  endtask

  task automatic test_redirect_same();
    bit found;
    lat = 1;
    ird = 1'b1;
    rdy_fix = 1'b1;
    redir_tgt = 32'h203;
    redir_fired = 1'b0;
    redir_busy = 1'b1;
    for (int i = 0; i < 20 && !redir_fired; i++) tick();
    n_total++;
    if (!redir_fired) $display("FAIL same_cycle_setup: redirect fired %b, expected 1", redir_fired);
    else n_pass++;
    redir_busy = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (acc_seen) begin
        found = 1'b1;
        break;
      end
    end
    n_total++;
    if (!found || acc_addr !== 32'h200)
      $display("FAIL same_cycle_addr: got %h (seen %b), expected 00000200", acc_addr, found);
    else n_pass++;
    found = pop_seen;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      found = pop_seen;
    end
    n_total++;
    if (!found || pop_pc !== 32'h200)
      $display("FAIL same_cycle_pop: got %h (seen %b), expected 00000200", pop_pc, found);
    else n_pass++;
  endtask

  task automatic test_random();
    int start;
    start = pops;
    rdy_rand = 1'b1;
    lat_rand = 1'b1;
    ird_rand = 1'b1;
    repeat (600) begin
      if ($urandom_range(0, 49) == 0) begin
        redir_now = 1'b1;
        redir_tgt = $urandom;
      end
      tick();
    end
    rdy_rand = 1'b0;
    rdy_fix  = 1'b0;
    ird_rand = 1'b0;
    ird = 1'b1;
    repeat (20) tick();
    n_total++;
    if (pops - start < 50) $display("FAIL random_rate: got %0d pops, expected >= 50", pops - start);
    else n_pass++;
    n_total++;
    if (exp_q.size() !== 0 || instr_valid !== 1'b0)
      $display("FAIL random_drain: %0d expected words left, instr_valid %b, expected 0 0",
               exp_q.size(), instr_valid);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    model_pc       = 32'h0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_wrap();
    test_stall();
    test_redirect();
    test_redirect_same();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
